mcsr_trap_unit: RTL

Parametrised machine-mode CSR file and trap/interrupt controller for the RV32 core, replacing the fixed single-interrupt CSR block. Sits beside the execute stage: serves Zicsr reads/writes, arbitrates exceptions, prioritised interrupts (standard plus `NUM_IRQ` platform lines) and MRET, and issues a registered redirect to fetch. Adds M/U privilege tracking, vectored `mtvec`, `mtval`, and wrapping 64-bit counters.

---
 rtl/mcsr_trap_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mcsr_trap_unit.sv
// rtl/mcsr_trap_unit.sv - machine-mode CSR file with trap/interrupt arbitration and fetch redirect
module mcsr_trap_unit #(
   parameter int          NUM_IRQ     = 4,
   parameter bit          VECTORED_EN = 1'b1,
   parameter bit          COUNTER_EN  = 1'b1,
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
   parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               csr_valid,
   input  logic [11:0]        csr_addr,
   input  logic [2:0]         csr_op,
   input  logic [31:0]        csr_rs1,
   input  logic [4:0]         csr_zimm,
   input  logic               csr_src_nz,
   output logic [31:0]        csr_rdata,
   output logic               csr_illegal,
   input  logic               exc_valid,
   input  logic [4:0]         exc_cause,
   input  logic [31:0]        exc_pc,
   input  logic [31:0]        exc_tval,
   input  logic               mret_valid,
   input  logic               instr_retire,
   input  logic               irq_ext,
   input  logic               irq_timer,
   input  logic               irq_soft,
   input  logic [NUM_IRQ-1:0] irq_plat,
   input  logic               irq_ok,
   input  logic [31:0]        current_pc,
   output logic               redirect_valid,
   output logic [31:0]        redirect_pc,
   output logic [1:0]         priv_mode
);

   // Implemented interrupt bits: MSI, MTI, MEI plus the platform lines at 16 upward.
   localparam logic [31:0] IRQ_MASK = 32'h0000_0888 | (((32'd1 << NUM_IRQ) - 32'd1) << 16);

   logic        priv_m;
   logic        st_mie, st_mpie;
   logic [1:0]  st_mpp;
   logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
   logic [63:0] mcycle_q, minstret_q;

   logic [31:0] mip, pend, mstatus_rd, src, wdata, tvec_base, trap_pc;
   logic [63:0] cyc_nxt, ret_nxt;
   logic [4:0]  irq_code;
   logic        addr_ok, addr_ro, wr_req, csr_fault, blocked;
   logic        take_exc, take_irq, take_mret, do_write;

   assign priv_mode  = priv_m ? 2'b11 : 2'b00;
   assign mstatus_rd = {19'b0, st_mpp, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
   assign blocked    = redirect_valid;

   // Live interrupt inputs mapped onto their mip bit positions.
   always_comb begin
      mip     = '0;
      mip[3]  = irq_soft;
      mip[7]  = irq_timer;
      mip[11] = irq_ext;
      for (int i = 0; i < NUM_IRQ; i++) mip[16+i] = irq_plat[i];
   end

   // CSR read mux plus address legality and read-only classification.
   always_comb begin
      csr_rdata = '0;
      addr_ok   = 1'b1;
      addr_ro   = 1'b0;
      case (csr_addr)
         12'h300: csr_rdata = mstatus_rd;
         12'h301: csr_rdata = 32'h4010_1100;
         12'h304: csr_rdata = mie_q;
         12'h305: csr_rdata = mtvec_q;
         12'h340: csr_rdata = mscratch_q;
         12'h341: csr_rdata = mepc_q;
         12'h342: csr_rdata = mcause_q;
         12'h343: csr_rdata = mtval_q;
         12'h344: csr_rdata = mip & IRQ_MASK;
         12'hB00: csr_rdata = mcycle_q[31:0];
         12'hB80: csr_rdata = mcycle_q[63:32];
         12'hB02: csr_rdata = minstret_q[31:0];
         12'hB82: csr_rdata = minstret_q[63:32];
         12'hF11, 12'hF12: addr_ro = 1'b1;
         12'hF13: begin csr_rdata = 32'd2;   addr_ro = 1'b1; end
         12'hF14: begin csr_rdata = HART_ID; addr_ro = 1'b1; end
         default: addr_ok = 1'b0;
      endcase
   end

   // Write data formation; set/clear forms with a zero source are pure reads.
   always_comb begin
      src    = csr_op[2] ? {27'b0, csr_zimm} : csr_rs1;
      wr_req = csr_valid && ((csr_op[1:0] == 2'b01) || ((csr_op[1:0] != 2'b00) && csr_src_nz));
      case (csr_op[1:0])
         2'b01:   wdata = src;
         2'b10:   wdata = csr_rdata | src;
         2'b11:   wdata = csr_rdata & ~src;
         default: wdata = csr_rdata;
      endcase
   end

   assign csr_fault   = csr_valid && (!priv_m || !addr_ok || (addr_ro && wr_req));
   assign csr_illegal = !blocked && (csr_fault || (mret_valid && !priv_m));

   // Interrupt selection: later assignments win, giving 11 > 3 > 7 > 16 > 17 > ...
   always_comb begin
      pend     = mip & mie_q;
      irq_code = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) if (pend[16+i]) irq_code = 5'(16 + i);
      if (pend[7])  irq_code = 5'd7;
      if (pend[3])  irq_code = 5'd3;
      if (pend[11]) irq_code = 5'd11;
   end

   assign take_exc  = exc_valid && !blocked;
   assign take_irq  = !blocked && !exc_valid && (|pend) && irq_ok && (!priv_m || st_mie);
   assign take_mret = !blocked && !exc_valid && !take_irq && mret_valid && priv_m;
   assign do_write  = wr_req && !blocked && !csr_fault && !take_exc && !take_irq && !take_mret;

   assign tvec_base = {mtvec_q[31:2], 2'b00};
   assign trap_pc   = (take_irq && (mtvec_q[1:0] == 2'b01)) ? tvec_base + {25'b0, irq_code, 2'b00}
                                                             : tvec_base;

   // Counter increment with per-half CSR write override.
   always_comb begin
      cyc_nxt = mcycle_q + 64'd1;
      ret_nxt = minstret_q + {63'd0, instr_retire};
      if (do_write) begin
         case (csr_addr)
            12'hB00: cyc_nxt[31:0]  = wdata;
            12'hB80: cyc_nxt[63:32] = wdata;
            12'hB02: ret_nxt[31:0]  = wdata;
            12'hB82: ret_nxt[63:32] = wdata;
            default: ;
         endcase
      end
   end

   // Privilege, status and trap CSR state: trap entry, MRET, then software writes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         priv_m     <= 1'b1;
         st_mie     <= 1'b0;
         st_mpie    <= 1'b0;
         st_mpp     <= 2'b00;
         mie_q      <= '0;
         mtvec_q    <= RESET_MTVEC;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
      end else if (take_exc || take_irq) begin
         mepc_q   <= take_exc ? {exc_pc[31:2], 2'b00} : {current_pc[31:2], 2'b00};
         mcause_q <= take_exc ? {27'b0, exc_cause} : {1'b1, 26'b0, irq_code};
         mtval_q  <= take_exc ? exc_tval : 32'd0;
         st_mpie  <= st_mie;
         st_mie   <= 1'b0;
         st_mpp   <= priv_m ? 2'b11 : 2'b00;
         priv_m   <= 1'b1;
      end else if (take_mret) begin
         priv_m  <= (st_mpp == 2'b11);
         st_mie  <= st_mpie;
         st_mpie <= 1'b1;
         st_mpp  <= 2'b00;
      end else if (do_write) begin
         case (csr_addr)
            12'h300: begin
               st_mie  <= wdata[3];
               st_mpie <= wdata[7];
               if ((wdata[12:11] == 2'b00) || (wdata[12:11] == 2'b11)) st_mpp <= wdata[12:11];
            end
            12'h304: mie_q      <= wdata & IRQ_MASK;
            12'h305: mtvec_q    <= {wdata[31:2], (VECTORED_EN && (wdata[1:0] == 2'b01)) ? 2'b01 : 2'b00};
            12'h340: mscratch_q <= wdata;
            12'h341: mepc_q     <= {wdata[31:2], 2'b00};
            12'h342: mcause_q   <= wdata;
            12'h343: mtval_q    <= wdata;
            default: ;
         endcase
      end
   end

   // Cycle and retired-instruction counters, advanced only when COUNTER_EN is set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else if (COUNTER_EN) begin
         mcycle_q   <= cyc_nxt;
         minstret_q <= ret_nxt;
      end
   end

   // One-cycle redirect pulse to fetch after any accepted trap or MRET.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         redirect_valid <= take_exc || take_irq || take_mret;
         if (take_exc || take_irq) redirect_pc <= trap_pc;
         else if (take_mret)       redirect_pc <= mepc_q;
      end
   end

endmodule
